uart_core_v2: RTL
=================

Name: uart_core_v2

Overview:
Parametrised next-generation UART for the debug unit: 16x-oversampled RX/TX with a runtime-programmable baud divisor, configurable word width and FIFO depth, glitch-rejecting start detection, and sticky framing/overrun error flags. It sits between the debug-unit command FSM and the board pins, replacing the fixed-rate UART. Both FIFOs are first-word-fall-through and expose fill levels.

Parameters:
DBIT, 8, data bits per frame (1..32), LSB first
SB_TICK, 16, oversample ticks for stop bit (16 = 1 stop, 32 = 2 stop)
DVSR_BIT, 16, width of baud_div
FIFO_W, 2, FIFO address bits; depth = 2^FIFO_W words per direction

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
baud_div  in  DVSR_BIT  clocks per 16x tick; 0 treated as 1
rx  in  1  serial input (asynchronous to clk)
tx  out  1  serial output, idle high
wr_uart  in  1  push w_data into TX FIFO
w_data  in  DBIT  TX word
rd_uart  in  1  pop RX FIFO head
r_data  out  DBIT  RX FIFO head, valid while rx_empty=0
tx_full  out  1  TX FIFO full
tx_empty  out  1  TX FIFO empty
rx_full  out  1  RX FIFO full
rx_empty  out  1  RX FIFO empty
tx_count  out  FIFO_W+1  TX FIFO occupancy
rx_count  out  FIFO_W+1  RX FIFO occupancy
tx_busy  out  1  transmitter not in IDLE
frame_err  out  1  sticky: stop bit sampled low
overrun_err  out  1  sticky: RX word lost, FIFO full
err_clr  in  1  clears both sticky flags

Behaviour:
- Reset (async assert, sync release): tx=1, tx_busy=0, both FIFOs empty (tx_empty=rx_empty=1, full=0, counts=0), r_data=0, errors=0, FSMs IDLE, baud counter 0, rx synchroniser =1.
- Baud gen: counter 0..max(baud_div,1)-1, one-cycle tick at terminal count; new baud_div takes effect at the next wrap.
- rx passes a 2-flop synchroniser (reset 1); all RX sampling uses synchronised value.
- RX FSM IDLE->START on rx=0; START: after 7 ticks re-sample, rx=0 -> DATA, rx=1 -> IDLE (glitch reject). DATA: sample every 16 ticks, DBIT bits, LSB first. STOP: sample after SB_TICK ticks -> IDLE.
- Stop sampled 0: word discarded, frame_err=1. Stop 1 with RX FIFO full: word discarded, overrun_err=1. Otherwise word written; rx_empty falls 1 clk after stop sample.
- Error flags: set has priority over err_clr in the same cycle.
- TX FSM IDLE->START when TX FIFO non-empty; head popped and latched on IDLE->START exit (one cycle), so a FIFO slot frees at frame start. START 16 ticks low, DATA 16 ticks/bit LSB first, STOP SB_TICK ticks high, then IDLE; back-to-back frames with no extra idle bit time beyond one tick alignment.
- FIFO rules: wr when full ignored; rd when empty ignored; rd+wr when full: both succeed, count unchanged; rd+wr when empty: write only. Pointers wrap modulo 2^FIFO_W.
- Reset mid-frame: immediate abort, tx driven high same cycle, partial words discarded.

Optional Feature:
UART_PARITY_EN: adds port parity_odd (in, 1). TX inserts parity bit after data (even when parity_odd=0); RX samples it in a PARITY state and adds sticky output parity_err (set-priority over err_clr); word with parity error discarded. Without the macro: no PARITY state, no parity_odd/parity_err ports, frame = start+DBIT+stop.

Decomposition:
- Package uart_v2_pkg: RX/TX state encodings, OVERSAMPLE=16, START_MID=7 constants.
- Sub-module uart_fifo_fwft (params B, W; ports clk, reset, rd, wr, w_data, r_data, empty, full, count), instantiated twice; baud gen, RX and TX FSMs inline.

Test Plan:
- DBIT=8, baud_div=4, write 0xA5 -> tx low 64 clk, then bits 1,0,1,0,0,1,0,1 each 64 clk, stop high 64 clk; frame 640 clk; tx_busy high throughout.
- tx looped to rx, write 0x3C, 0xFF, 0x00 -> rx_count reaches 3, reads return 0x3C, 0xFF, 0x00 in order, no error flags.
- FIFO_W=2, receive 5 words without rd_uart -> rx_full=1, rx_count=4, overrun_err=1, fifth word absent; err_clr -> overrun_err=0.
- Frame with stop bit driven low -> frame_err=1, rx_empty stays 1; rx pulse low for 3 ticks -> no reception, RX FSM returns IDLE.
- baud_div=0 -> tick every clk, 0x5A frame takes 160 clk; rd+wr on full FIFO -> count stays 4, order preserved.
- reset asserted mid-DATA of TX -> tx=1 and tx_empty=1 same cycle; with UART_PARITY_EN, parity_odd=1, 0x01 -> parity bit 0; corrupted parity -> parity_err=1.

Source files
------------

// File: rtl/uart_v2_pkg.sv
// Shared constants and FSM state encodings for uart_core_v2.
// UART_PARITY_EN adds the PARITY state to both FSMs.
package uart_v2_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int START_MID  = 7;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
`ifdef UART_PARITY_EN
        RX_PARITY,
`endif
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
`ifdef UART_PARITY_EN
        TX_PARITY,
`endif
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/uart_fifo_fwft.sv
// First-word-fall-through FIFO with occupancy count; depth 2^W words of B bits.
// r_data shows the head word and reads as zero while the FIFO is empty.
module uart_fifo_fwft #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rd,
    input  logic         wr,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic         empty,
    output logic         full,
    output logic [W:0]   count
);

    localparam logic [W:0] DEPTH = {1'b1, {W{1'b0}}};

    logic [B-1:0] mem [2**W];
    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign empty  = (count == '0);
    assign full   = (count == DEPTH);
    assign do_rd  = rd && !empty;
    // A write into a full FIFO is allowed only when a read frees the head slot in the same cycle.
    assign do_wr  = wr && (!full || rd);
    assign r_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= w_data;
    end

endmodule

// File: rtl/uart_core_v2.sv
// 16x-oversampled UART with programmable baud divisor, FWFT FIFOs and sticky error flags.
// Define UART_PARITY_EN to add a parity bit (parity_odd in, parity_err out).
module uart_core_v2 #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int DVSR_BIT = 16,
    parameter int FIFO_W   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DVSR_BIT-1:0] baud_div,
    input  logic                rx,
    output logic                tx,
    input  logic                wr_uart,
    input  logic [DBIT-1:0]     w_data,
    input  logic                rd_uart,
    output logic [DBIT-1:0]     r_data,
    output logic                tx_full,
    output logic                tx_empty,
    output logic                rx_full,
    output logic                rx_empty,
    output logic [FIFO_W:0]     tx_count,
    output logic [FIFO_W:0]     rx_count,
    output logic                tx_busy,
    output logic                frame_err,
`ifdef UART_PARITY_EN
    input  logic                parity_odd,
    output logic                parity_err,
`endif
    output logic                overrun_err,
    input  logic                err_clr
);

    import uart_v2_pkg::*;

    logic [DVSR_BIT-1:0] baud_cnt, div_q, div_eff;
    logic                tick;
    logic                rx_meta, rx_sync;

    rx_state_t           rx_state, rx_state_next;
    logic [5:0]          rx_s, rx_s_next, rx_n, rx_n_next;
    logic [DBIT-1:0]     rx_b, rx_b_next;
    logic                rx_stop_tick, rx_par_bad, rx_wr;
    logic                frame_set, overrun_set;

    tx_state_t           tx_state, tx_state_next;
    logic [5:0]          tx_s, tx_s_next, tx_n, tx_n_next;
    logic [DBIT-1:0]     tx_b, tx_b_next, tx_head;
    logic                tx_rd, tx_line;

    // The divisor is latched at each wrap so a new baud_div never truncates a running period.
    assign div_eff = (baud_div == '0) ? DVSR_BIT'(1) : baud_div;
    assign tick    = (baud_cnt == div_q - 1'b1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
            div_q    <= DVSR_BIT'(1);
            rx_meta  <= 1'b1;
            rx_sync  <= 1'b1;
        end else begin
            baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
            if (tick)
                div_q <= div_eff;
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    uart_fifo_fwft #(.B(DBIT), .W(FIFO_W)) tx_fifo (
        .clk(clk), .reset(reset), .rd(tx_rd), .wr(wr_uart), .w_data(w_data),
        .r_data(tx_head), .empty(tx_empty), .full(tx_full), .count(tx_count)
    );

    uart_fifo_fwft #(.B(DBIT), .W(FIFO_W)) rx_fifo (
        .clk(clk), .reset(reset), .rd(rd_uart), .wr(rx_wr), .w_data(rx_b),
        .r_data(r_data), .empty(rx_empty), .full(rx_full), .count(rx_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state <= RX_IDLE;
            rx_s     <= '0;
            rx_n     <= '0;
            rx_b     <= '0;
        end else begin
            rx_state <= rx_state_next;
            rx_s     <= rx_s_next;
            rx_n     <= rx_n_next;
            rx_b     <= rx_b_next;
        end
    end

    // START re-samples at mid-bit so a short low glitch drops back to IDLE.
    always_comb begin
        rx_state_next = rx_state;
        rx_s_next     = rx_s;
        rx_n_next     = rx_n;
        rx_b_next     = rx_b;
        rx_stop_tick  = 1'b0;
        case (rx_state)
            RX_IDLE:
                if (!rx_sync) begin
                    rx_state_next = RX_START;
                    rx_s_next     = '0;
                end
            RX_START:
                if (tick) begin
                    if (rx_s == 6'(START_MID)) begin
                        rx_s_next     = '0;
                        rx_n_next     = '0;
                        rx_state_next = rx_sync ? RX_IDLE : RX_DATA;
                    end else
                        rx_s_next = rx_s + 1'b1;
                end
            RX_DATA:
                if (tick) begin
                    if (rx_s == 6'(OVERSAMPLE - 1)) begin
                        rx_s_next = '0;
                        rx_b_next = DBIT'({rx_sync, rx_b} >> 1);
                        if (rx_n == 6'(DBIT - 1))
`ifdef UART_PARITY_EN
                            rx_state_next = RX_PARITY;
`else
                            rx_state_next = RX_STOP;
`endif
                        else
                            rx_n_next = rx_n + 1'b1;
                    end else
                        rx_s_next = rx_s + 1'b1;
                end
`ifdef UART_PARITY_EN
            RX_PARITY:
                if (tick) begin
                    if (rx_s == 6'(OVERSAMPLE - 1)) begin
                        rx_s_next     = '0;
                        rx_state_next = RX_STOP;
                    end else
                        rx_s_next = rx_s + 1'b1;
                end
`endif
            RX_STOP:
                if (tick) begin
                    if (rx_s == 6'(SB_TICK - 1)) begin
                        rx_stop_tick  = 1'b1;
                        rx_state_next = RX_IDLE;
                    end else
                        rx_s_next = rx_s + 1'b1;
                end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        frame_set   = rx_stop_tick && !rx_sync;
        overrun_set = rx_stop_tick && rx_sync && !rx_par_bad && rx_full;
        rx_wr       = rx_stop_tick && rx_sync && !rx_par_bad && !rx_full;
    end

    // Setting a flag wins over a simultaneous err_clr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            frame_err   <= frame_set | (frame_err & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

`ifdef UART_PARITY_EN
    logic rx_p, tx_p;

    assign rx_par_bad = (^{rx_b, rx_p}) ^ parity_odd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_p       <= 1'b0;
            tx_p       <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (rx_state == RX_PARITY && tick && rx_s == 6'(OVERSAMPLE - 1))
                rx_p <= rx_sync;
            if (tx_rd)
                tx_p <= (^tx_head) ^ parity_odd;
            parity_err <= (rx_stop_tick && rx_sync && rx_par_bad) | (parity_err & ~err_clr);
        end
    end
`else
    assign rx_par_bad = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= TX_IDLE;
            tx_s     <= '0;
            tx_n     <= '0;
            tx_b     <= '0;
            tx       <= 1'b1;
        end else begin
            tx_state <= tx_state_next;
            tx_s     <= tx_s_next;
            tx_n     <= tx_n_next;
            tx_b     <= tx_b_next;
            tx       <= tx_line;
        end
    end

    // Leaving IDLE only on a tick makes the start bit a full 16 ticks long.
    always_comb begin
        tx_state_next = tx_state;
        tx_s_next     = tx_s;
        tx_n_next     = tx_n;
        tx_b_next     = tx_b;
        case (tx_state)
            TX_IDLE:
                if (tick && !tx_empty) begin
                    tx_state_next = TX_START;
                    tx_s_next     = '0;
                    tx_b_next     = tx_head;
                end
            TX_START:
                if (tick) begin
                    if (tx_s == 6'(OVERSAMPLE - 1)) begin
                        tx_s_next     = '0;
                        tx_n_next     = '0;
                        tx_state_next = TX_DATA;
                    end else
                        tx_s_next = tx_s + 1'b1;
                end
            TX_DATA:
                if (tick) begin
                    if (tx_s == 6'(OVERSAMPLE - 1)) begin
                        tx_s_next = '0;
                        tx_b_next = tx_b >> 1;
                        if (tx_n == 6'(DBIT - 1))
`ifdef UART_PARITY_EN
                            tx_state_next = TX_PARITY;
`else
                            tx_state_next = TX_STOP;
`endif
                        else
                            tx_n_next = tx_n + 1'b1;
                    end else
                        tx_s_next = tx_s + 1'b1;
                end
`ifdef UART_PARITY_EN
            TX_PARITY:
                if (tick) begin
                    if (tx_s == 6'(OVERSAMPLE - 1)) begin
                        tx_s_next     = '0;
                        tx_state_next = TX_STOP;
                    end else
                        tx_s_next = tx_s + 1'b1;
                end
`endif
            TX_STOP:
                if (tick) begin
                    if (tx_s == 6'(SB_TICK - 1))
                        tx_state_next = TX_IDLE;
                    else
                        tx_s_next = tx_s + 1'b1;
                end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_rd   = (tx_state == TX_IDLE) && tick && !tx_empty;
        tx_busy = (tx_state != TX_IDLE);
        tx_line = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_b[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_line = tx_p;
`endif
            default:   tx_line = 1'b1;
        endcase
    end

endmodule
